// File: rtl/seq_chain_ctrl_if.sv
// rtl/seq_chain_ctrl_if.sv - control/status bundle between the chain sequencer, its controller and the sub-units
interface seq_chain_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int TMO_W      = 8,
  localparam int IDX_W     = $clog2(NUM_STAGES)
);
  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_en;
  logic [TMO_W-1:0]      timeout_cycles;
  logic [NUM_STAGES-1:0] done_vec;
  logic [NUM_STAGES-1:0] start_vec;
  logic                  done;
  logic                  error;
  logic                  busy;
  logic [IDX_W-1:0]      stage_idx;

  modport master (
    output start, abort, stage_en, timeout_cycles, done_vec,
    input  start_vec, done, error, busy, stage_idx
  );

  modport slave (
    input  start, abort, stage_en, timeout_cycles, done_vec,
    output start_vec, done, error, busy, stage_idx
  );
endinterface

// File: rtl/seq_chain_ctrl.sv
// rtl/seq_chain_ctrl.sv - Mealy sequencer pulsing enabled stages in order, with skip mask, per-stage timeout and abort
module seq_chain_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int TMO_W      = 8,
  localparam int IDX_W     = $clog2(NUM_STAGES)
) (
  input logic             clk,
  input logic             reset,
  seq_chain_ctrl_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      cur, cur_nxt;
  logic [TMO_W-1:0]      cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] en_q, en_q_nxt;

  logic                  first_hit;
  logic [IDX_W-1:0]      first_idx;
  logic                  next_hit;
  logic [IDX_W-1:0]      next_idx;
  logic                  tmo_hit;
  logic [NUM_STAGES-1:0] start_vec_c;
  logic                  done_c;
  logic                  error_c;

  // Descending scan leaves the lowest matching index in the result.
  always_comb begin : find_stage
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (bus.stage_en[i]) begin
        first_hit = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (en_q[i] && (i > int'(cur))) begin
        next_hit = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  assign tmo_hit = (bus.timeout_cycles != '0) &&
                   (cnt == bus.timeout_cycles - TMO_W'(1));

  always_comb begin : fsm_next
    state_nxt   = state;
    cur_nxt     = cur;
    cnt_nxt     = cnt;
    en_q_nxt    = en_q;
    start_vec_c = '0;
    done_c      = 1'b0;
    error_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          en_q_nxt = bus.stage_en;
          if (first_hit) begin
            start_vec_c[first_idx] = 1'b1;
            state_nxt              = WAIT;
            cur_nxt                = first_idx;
            cnt_nxt                = '0;
          end else begin
            done_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          cur_nxt   = '0;
          cnt_nxt   = '0;
        end else if (bus.done_vec[cur]) begin
          if (next_hit) begin
            start_vec_c[next_idx] = 1'b1;
            cur_nxt               = next_idx;
            cnt_nxt               = '0;
          end else begin
            done_c    = 1'b1;
            state_nxt = IDLE;
            cur_nxt   = '0;
            cnt_nxt   = '0;
          end
        end else if (tmo_hit) begin
          error_c   = 1'b1;
          state_nxt = IDLE;
          cur_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt != '1) begin
          // Saturate so a disabled timeout can never wrap into a false hit.
          cnt_nxt = cnt + TMO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      en_q  <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
      en_q  <= en_q_nxt;
    end
  end

  // Mealy pulses are masked so nothing escapes while reset is held.
  assign bus.start_vec = reset ? '0 : start_vec_c;
  assign bus.done      = done_c & ~reset;
  assign bus.error     = error_c & ~reset;
  assign bus.busy      = (state == WAIT);
  assign bus.stage_idx = (state == WAIT) ? cur : '0;
endmodule

// File: doc/seq_chain_ctrl.md
Name: seq_chain_ctrl

Overview:
- Parametrised Mealy sequencer that drives a chain of NUM_STAGES sub-units in order.
- For each enabled stage it pulses that stage's start line, then waits for the stage's done.
- Generalises the fixed three-stage start/done chain with:
  - a configurable stage count;
  - a per-run stage-enable mask (disabled stages are skipped);
  - a programmable per-stage timeout with error reporting;
  - an abort.
- Sits between a top-level controller (start/done/error) and the datapath sub-units.

Parameters:
- NUM_STAGES, 4, number of chained sub-units (>=2).
- TMO_W, 8, width of the timeout count.
- IDX_W, $clog2(NUM_STAGES), width of stage_idx (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  cancel the current run; sampled only in WAIT.
- stage_en  in  NUM_STAGES  per-stage enable mask; latched when a start is accepted.
- timeout_cycles  in  TMO_W  per-stage wait limit in cycles; 0 disables the timeout.
- done_vec  in  NUM_STAGES  done strobes from the sub-units; bit i belongs to stage i.
- start_vec  out  NUM_STAGES  one-hot, single-cycle start pulse to stage i (Mealy).
- done  out  1  single-cycle pulse when the run completes (Mealy).
- error  out  1  single-cycle pulse when a stage times out (Mealy).
- busy  out  1  high while in WAIT (registered state).
- stage_idx  out  IDX_W  index of the stage currently awaited; 0 in IDLE.

Behaviour:
- Reset:
  - While reset is high: state=IDLE, cur=0, cnt=0, en_q=0.
  - All outputs are 0 while reset is asserted, including the combinational ones.
  - A reset mid-run abandons the run immediately; no done or error pulse is issued.
- States: IDLE, WAIT. Registers:
  - cur (IDX_W): stage being awaited.
  - cnt (TMO_W): cycles spent waiting on the current stage.
  - en_q (NUM_STAGES): latched enable mask.
- first(m, k): lowest index j >= k with m[j]=1; "none" if no such j.
- IDLE with start=1:
  - en_q <= stage_en.
  - If first(stage_en, 0)=j: start_vec[j]=1 in the same cycle; next state WAIT with cur=j, cnt=0.
  - If stage_en is all zero: done=1 in the same cycle; remain in IDLE.
- IDLE without start:
  - All outputs 0.
  - abort and done_vec are ignored.
- WAIT: actions are evaluated in the following priority order each cycle.
  1. abort=1: next state IDLE; no pulses on start_vec, done or error.
  2. done_vec[cur]=1:
     - If first(en_q, cur+1)=j: start_vec[j]=1 this cycle; cur <= j, cnt <= 0.
     - Else: done=1 this cycle; next state IDLE.
  3. timeout_cycles!=0 and cnt==timeout_cycles-1: error=1 this cycle; next state IDLE.
  4. Otherwise: cnt <= cnt+1; hold state.
- Timeout accounting:
  - A stage gets exactly timeout_cycles WAIT cycles, counting from the cycle after its start pulse.
  - Done arriving in the final allowed cycle wins over the timeout.
  - cnt saturates at its maximum when the timeout is disabled and never wraps into a false timeout.
- Ignored inputs:
  - done_vec bits other than cur are ignored in WAIT.
  - start in WAIT is ignored; no queuing.
  - stage_en changes during WAIT have no effect, because en_q is used.
- Latency:
  - Start to start_vec pulse: 0 cycles (combinational).
  - done_vec[i] to the next stage's start_vec pulse, or to done: 0 cycles.
  - Minimum run time is one WAIT cycle per enabled stage.
- Back-to-back runs:
  - After done, start may be accepted in the very next cycle (IDLE).
  - start sampled in the same cycle as done is ignored, because the FSM is still in WAIT.
- Output constraints:
  - start_vec is always one-hot or zero.
  - done and error are mutually exclusive and never coincide with a start_vec pulse.
  - busy = (state==WAIT); stage_idx = cur in WAIT, else 0.

Test Plan:
- NUM_STAGES=4, stage_en=4'b1111, timeout_cycles=0; start pulse; each done_vec[i] returned 3 cycles after start_vec[i]:
  - start_vec shows 0001, 0010, 0100, 1000, each coincident with the trigger.
  - done=1 in the same cycle as done_vec[3].
  - busy is high for 12 cycles.
  - stage_idx steps 0,1,2,3.
- stage_en=4'b1010:
  - start -> start_vec=0010.
  - done_vec[1] -> start_vec=1000.
  - done_vec[3] -> done.
  - Stages 0 and 2 never pulse; stray done_vec[0] during WAIT is ignored.
- stage_en=4'b0000; start=1 -> done=1 the same cycle; busy stays 0.
- timeout_cycles=5, stage 1 never responds:
  - error=1 on the 5th WAIT cycle of stage 1, then IDLE.
  - Repeat with done_vec[1] in the 5th cycle -> stage 2 starts and no error.
- Abort on the 2nd WAIT cycle of stage 2, with done_vec[2] high in the same cycle:
  - Next cycle is IDLE; no start_vec[3], no done, no error.
  - A fresh start is accepted the following cycle.
- Reset asserted asynchronously mid-cycle while in WAIT at stage 2, with start held high:
  - All outputs drop to 0 immediately and stay 0 while reset is high.
  - After release with start=1, start_vec[0] pulses.
